// File: rtl/tlb_host_dma_sched.sv
`timescale 1ns/1ps
// Round-robin, credit-limited scheduler of per-region TLB DMA commands onto one host DMA port.
// Optional weighted round-robin (s_weight port) is enabled by defining TLB_SCHED_WRR_EN.
module tlb_host_dma_sched #(
    parameter int N_REQ         = 4,
    parameter int ADDR_BITS     = 64,
    parameter int LEN_BITS      = 28,
    parameter int N_OUTSTANDING = 8,
    parameter int ORD_DEPTH     = 16,
    parameter int ID_BITS       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [N_REQ-1:0]              s_req_valid,
    output logic [N_REQ-1:0]              s_req_ready,
    input  logic [N_REQ*ADDR_BITS-1:0]    s_req_paddr,
    input  logic [N_REQ*LEN_BITS-1:0]     s_req_len,
    input  logic [N_REQ-1:0]              s_req_last,
`ifdef TLB_SCHED_WRR_EN
    input  logic [N_REQ*4-1:0]            s_weight,
`endif
    output logic                          m_req_valid,
    input  logic                          m_req_ready,
    output logic [ADDR_BITS-1:0]          m_req_paddr,
    output logic [LEN_BITS-1:0]           m_req_len,
    output logic                          m_req_last,
    output logic                          m_ord_valid,
    input  logic                          m_ord_ready,
    output logic [ID_BITS-1:0]            m_ord_id,
    input  logic [N_REQ-1:0]              done_i
);
    // state | meaning
    // IDLE  | pick an eligible region, accept its command into the output register
    // ISSUE | hold the command on m_req until the host DMA accepts it

    localparam int CW = $clog2(N_OUTSTANDING + 1);
    localparam int AW = $clog2(ORD_DEPTH);
    localparam logic [CW-1:0] CRED_MAX = CW'(N_OUTSTANDING);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t                state_q, state_d;
    logic [ID_BITS-1:0]    sel_q, sel_d, rr_q, rr_d, pick, cand, sel_pick, sel_next;
    logic [ID_BITS:0]      sum;
    logic                  found, push, push_en, pop, full, empty;
    logic [ADDR_BITS-1:0]  paddr_q, paddr_d;
    logic [LEN_BITS-1:0]   len_q, len_d;
    logic                  last_q, last_d, err_q, err_d;
    logic [CW-1:0]         credit_q [N_REQ];
    logic [CW-1:0]         credit_d [N_REQ];
    logic [N_REQ-1:0]      elig;
    logic [ADDR_BITS-1:0]  paddr_a [N_REQ];
    logic [LEN_BITS-1:0]   len_a [N_REQ];
    logic [ID_BITS-1:0]    ord_mem_q [ORD_DEPTH];
    logic [ID_BITS-1:0]    ord_mem_d [ORD_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           cnt_q, cnt_d;

`ifdef TLB_SCHED_WRR_EN
    logic [3:0]            w_a [N_REQ];
    logic [4:0]            burst_q, burst_d, burst_inc;
    logic [ID_BITS-1:0]    hold_id_q, hold_id_d;
    logic                  hold;
`endif

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            paddr_a[i] = s_req_paddr[i*ADDR_BITS +: ADDR_BITS];
            len_a[i]   = s_req_len[i*LEN_BITS +: LEN_BITS];
            elig[i]    = s_req_valid[i] && (credit_q[i] != '0);
`ifdef TLB_SCHED_WRR_EN
            w_a[i]     = s_weight[i*4 +: 4];
`endif
        end
    end

    // First eligible region at or after the RR pointer, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_q} + (ID_BITS+1)'(k);
            if (sum >= (ID_BITS+1)'(N_REQ)) sum = sum - (ID_BITS+1)'(N_REQ);
            cand = sum[ID_BITS-1:0];
            if (!found && elig[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign sel_next = (sel_q == ID_BITS'(N_REQ - 1)) ? '0 : sel_q + 1'b1;

`ifdef TLB_SCHED_WRR_EN
    assign hold      = (burst_q != '0) && elig[hold_id_q];
    assign sel_pick  = hold ? hold_id_q : pick;
    assign burst_inc = burst_q + 5'd1;
`else
    assign sel_pick  = pick;
`endif

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_d        = rr_q;
        paddr_d     = paddr_q;
        len_d       = len_q;
        last_d      = last_q;
        s_req_ready = '0;
        push        = 1'b0;
`ifdef TLB_SCHED_WRR_EN
        burst_d     = burst_q;
        hold_id_d   = hold_id_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found && !full) begin
                    s_req_ready[sel_pick] = 1'b1;
                    sel_d   = sel_pick;
                    paddr_d = paddr_a[sel_pick];
                    len_d   = len_a[sel_pick];
                    last_d  = s_req_last[sel_pick];
                    state_d = S_ISSUE;
`ifdef TLB_SCHED_WRR_EN
                    burst_d   = hold ? burst_q : '0;
                    hold_id_d = sel_pick;
`endif
                end
            end
            S_ISSUE: begin
                if (m_req_ready) begin
                    push    = 1'b1;
                    state_d = S_IDLE;
`ifdef TLB_SCHED_WRR_EN
                    // Pointer rotates only once the winner has used up its w+1 grants.
                    if (burst_inc > {1'b0, w_a[sel_q]}) begin
                        burst_d = '0;
                        rr_d    = sel_next;
                    end else begin
                        burst_d = burst_inc;
                    end
`else
                    rr_d    = sel_next;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A completion and an issue in the same cycle for one region cancel out.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < N_REQ; i++) begin
            credit_d[i] = credit_q[i];
            if (push && (sel_q == ID_BITS'(i)) && !done_i[i]) begin
                credit_d[i] = credit_q[i] - 1'b1;
            end else if (done_i[i] && !(push && (sel_q == ID_BITS'(i)))) begin
                if (credit_q[i] == CRED_MAX) err_d = 1'b1;
                else                         credit_d[i] = credit_q[i] + 1'b1;
            end
        end
    end

    assign full    = (cnt_q == (AW+1)'(ORD_DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop     = !empty && m_ord_ready;
    assign push_en = push && (!full || pop);

    always_comb begin
        ord_mem_d = ord_mem_q;
        if (push_en) ord_mem_d[wr_ptr_q] = sel_q;
        wr_ptr_d = wr_ptr_q + AW'(push_en);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q;
        if (push_en && !pop)      cnt_d = cnt_q + 1'b1;
        else if (!push_en && pop) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            rr_q     <= '0;
            paddr_q  <= '0;
            len_q    <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < N_REQ; i++) credit_q[i] <= CRED_MAX;
`ifdef TLB_SCHED_WRR_EN
            burst_q   <= '0;
            hold_id_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_q     <= rr_d;
            paddr_q  <= paddr_d;
            len_q    <= len_d;
            last_q   <= last_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            for (int i = 0; i < N_REQ; i++) credit_q[i] <= credit_d[i];
`ifdef TLB_SCHED_WRR_EN
            burst_q   <= burst_d;
            hold_id_q <= hold_id_d;
`endif
        end
    end

    always_ff @(posedge aclk) begin
        ord_mem_q <= ord_mem_d;
    end

    assign m_req_valid = (state_q == S_ISSUE);
    assign m_req_paddr = paddr_q;
    assign m_req_len   = len_q;
    assign m_req_last  = last_q;
    assign m_ord_valid = !empty;
    assign m_ord_id    = ord_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_tlb_host_dma_sched.sv
`timescale 1ns/1ps
// Directed bench for tlb_host_dma_sched: grant order, credits, ordering FIFO, backpressure, reset.
module tb_tlb_host_dma_sched;
    localparam int NR = 4;
    localparam int AB = 64;
    localparam int LB = 28;
    localparam int IB = 2;

    logic              aclk;
    logic              aresetn;
    logic [NR-1:0]     s_req_valid, s_req_ready, s_req_last, done_i;
    logic [NR*AB-1:0]  s_req_paddr;
    logic [NR*LB-1:0]  s_req_len;
    logic              m_req_valid, m_req_ready, m_req_last;
    logic [AB-1:0]     m_req_paddr;
    logic [LB-1:0]     m_req_len;
    logic              m_ord_valid, m_ord_ready;
    logic [IB-1:0]     m_ord_id;
`ifdef TLB_SCHED_WRR_EN
    logic [NR*4-1:0]   s_weight;
`endif

    tlb_host_dma_sched dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .s_req_valid (s_req_valid),
        .s_req_ready (s_req_ready),
        .s_req_paddr (s_req_paddr),
        .s_req_len   (s_req_len),
        .s_req_last  (s_req_last),
`ifdef TLB_SCHED_WRR_EN
        .s_weight    (s_weight),
`endif
        .m_req_valid (m_req_valid),
        .m_req_ready (m_req_ready),
        .m_req_paddr (m_req_paddr),
        .m_req_len   (m_req_len),
        .m_req_last  (m_req_last),
        .m_ord_valid (m_ord_valid),
        .m_ord_ready (m_ord_ready),
        .m_ord_id    (m_ord_id),
        .done_i      (done_i)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    bit echo_en = 1'b0;
    int echo_set [NR];
    int echo_done [NR];
    int gnt_q [$];
    int gnt_cyc [$];
    int iss_cyc [$];
    logic [AB-1:0] iss_paddr [$];
    logic [LB-1:0] iss_len [$];
    logic          iss_last [$];
    int pop_q [$];

    always @(posedge aclk) cyc <= cyc + 1;

    // Observe handshakes on the falling edge, away from the active edge.
    always @(negedge aclk) begin
        if (aresetn) begin
            for (int i = 0; i < NR; i++) begin
                if (s_req_valid[i] && s_req_ready[i]) begin
                    gnt_q.push_back(i);
                    gnt_cyc.push_back(cyc);
                end
            end
            if (m_req_valid && m_req_ready) begin
                iss_paddr.push_back(m_req_paddr);
                iss_len.push_back(m_req_len);
                iss_last.push_back(m_req_last);
                iss_cyc.push_back(cyc);
                if (echo_en && gnt_q.size() > 0) echo_set[gnt_q[gnt_q.size()-1]]++;
            end
            if (m_ord_valid && m_ord_ready) pop_q.push_back(int'(m_ord_id));
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        done_i = '0;
        if (echo_en) begin
            for (int i = 0; i < NR; i++) begin
                if (echo_set[i] > echo_done[i]) begin
                    done_i[i] = 1'b1;
                    echo_done[i]++;
                end
            end
        end
    endtask

    task automatic reset_dut();
        echo_en     = 1'b0;
        s_req_valid = '0;
        done_i      = '0;
        aresetn     = 1'b0;
        tick();
        tick();
        aresetn = 1'b1;
        for (int i = 0; i < NR; i++) echo_done[i] = echo_set[i];
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g0, i0, p0, n0;
        for (int i = 0; i < NR; i++) begin
            echo_set[i]  = 0;
            echo_done[i] = 0;
        end
        aresetn     = 1'b0;
        s_req_valid = '0;
        s_req_paddr = '0;
        s_req_len   = '0;
        s_req_last  = '0;
        done_i      = '0;
        m_req_ready = 1'b0;
        m_ord_ready = 1'b0;
`ifdef TLB_SCHED_WRR_EN
        s_weight    = '0;
`endif
        repeat (3) tick();

        // Reset state
        chk("rst_m_req_valid", 64'(m_req_valid), 64'd0);
        chk("rst_m_ord_valid", 64'(m_ord_valid), 64'd0);
        chk("rst_s_req_ready", 64'(s_req_ready), 64'd0);
        for (int i = 0; i < NR; i++) chk($sformatf("rst_credit%0d", i), 64'(dut.credit_q[i]), 64'd8);
        aresetn = 1'b1;
        tick();

        // Single requester: region 2, three commands
        g0 = gnt_q.size(); i0 = iss_paddr.size(); p0 = pop_q.size();
        m_req_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_req_valid[2]            = 1'b1;
            s_req_paddr[2*AB +: AB]   = 64'h1000 * 64'(k + 1);
            s_req_len[2*LB +: LB]     = 28'd4096;
            s_req_last[2]             = (k == 2);
            n0 = gnt_q.size();
            for (int t = 0; t < 20 && gnt_q.size() == n0; t++) tick();
            chk($sformatf("t1_grant_seen%0d", k), 64'(gnt_q.size()), 64'(n0 + 1));
        end
        s_req_valid = '0;
        repeat (3) tick();
        chk("t1_issue_count", 64'(iss_paddr.size() - i0), 64'd3);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t1_gnt_id%0d", k), 64'(gnt_q[g0+k]), 64'd2);
            chk($sformatf("t1_paddr%0d", k), iss_paddr[i0+k], 64'h1000 * 64'(k + 1));
            chk($sformatf("t1_len%0d", k), 64'(iss_len[i0+k]), 64'd4096);
            chk($sformatf("t1_last%0d", k), 64'(iss_last[i0+k]), (k == 2) ? 64'd1 : 64'd0);
            chk($sformatf("t1_latency%0d", k), 64'(iss_cyc[i0+k] - gnt_cyc[g0+k]), 64'd1);
        end
        chk("t1_credit2", 64'(dut.credit_q[2]), 64'd5);
        chk("t1_ord_valid", 64'(m_ord_valid), 64'd1);
        chk("t1_ord_head", 64'(m_ord_id), 64'd2);
        m_ord_ready = 1'b1;
        repeat (4) tick();
        m_ord_ready = 1'b0;
        chk("t1_pop_count", 64'(pop_q.size() - p0), 64'd3);
        for (int k = 0; k < 3; k++) chk($sformatf("t1_pop_id%0d", k), 64'(pop_q[p0+k]), 64'd2);
        chk("t1_ord_empty", 64'(m_ord_valid), 64'd0);
        for (int k = 0; k < 3; k++) begin
            done_i = 4'b0100;
            tick();
        end
        chk("t1_credit2_restored", 64'(dut.credit_q[2]), 64'd8);

        // Fairness: all regions valid, completions echoed
        reset_dut();
        g0 = gnt_q.size();
        echo_en = 1'b1; m_req_ready = 1'b1; m_ord_ready = 1'b1;
        s_req_valid = 4'hF;
        for (int t = 0; t < 100 && (gnt_q.size() - g0) < 16; t++) tick();
        s_req_valid = '0;
        chk("t2_grant_count", 64'(gnt_q.size() - g0), 64'd16);
        for (int k = 0; k < 16; k++) chk($sformatf("t2_order%0d", k), 64'(gnt_q[g0+k]), 64'(k % 4));
        repeat (6) tick();
        for (int i = 0; i < NR; i++) chk($sformatf("t2_credit%0d", i), 64'(dut.credit_q[i]), 64'd8);

        // Credit exhaustion: region 0, no completions
        reset_dut();
        g0 = gnt_q.size();
        m_req_ready = 1'b1; m_ord_ready = 1'b1;
        s_req_valid = 4'b0001;
        repeat (40) tick();
        chk("t3_grants_exhaust", 64'(gnt_q.size() - g0), 64'd8);
        chk("t3_ready_blocked", 64'(s_req_ready), 64'd0);
        done_i = 4'b0001;
        tick();
        repeat (10) tick();
        chk("t3_grants_after_done", 64'(gnt_q.size() - g0), 64'd9);
        chk("t3_ready_blocked2", 64'(s_req_ready), 64'd0);
        s_req_valid = '0;

        // Backpressure: ordering FIFO not drained
        reset_dut();
        g0 = gnt_q.size(); p0 = pop_q.size();
        echo_en = 1'b1; m_req_ready = 1'b1; m_ord_ready = 1'b0;
        s_req_paddr[1*AB +: AB] = 64'hABC000;
        s_req_valid = 4'b0010;
        repeat (60) tick();
        chk("t4_grants_full", 64'(gnt_q.size() - g0), 64'd16);
        chk("t4_ord_valid", 64'(m_ord_valid), 64'd1);
        chk("t4_ready_blocked", 64'(s_req_ready), 64'd0);
        m_req_ready = 1'b0;
        m_ord_ready = 1'b1;
        tick();
        m_ord_ready = 1'b0;
        chk("t4_one_pop", 64'(pop_q.size() - p0), 64'd1);
        chk("t4_pop_id", 64'(pop_q[p0]), 64'd1);
        for (int t = 0; t < 10 && (gnt_q.size() - g0) == 16; t++) tick();
        chk("t4_grant_after_pop", 64'(gnt_q.size() - g0), 64'd17);
        s_req_paddr[1*AB +: AB] = 64'hDEAD000;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t4_stall_valid%0d", k), 64'(m_req_valid), 64'd1);
            chk($sformatf("t4_stall_paddr%0d", k), m_req_paddr, 64'hABC000);
            tick();
        end
        chk("t4_no_extra_grant", 64'(gnt_q.size() - g0), 64'd17);

        // Reset while ISSUE is stalled
        i0 = iss_paddr.size();
        echo_en = 1'b0;
        aresetn = 1'b0;
        #1;
        chk("t5_m_req_valid", 64'(m_req_valid), 64'd0);
        chk("t5_m_ord_valid", 64'(m_ord_valid), 64'd0);
        for (int i = 0; i < NR; i++) chk($sformatf("t5_credit%0d", i), 64'(dut.credit_q[i]), 64'd8);
        s_req_valid = '0;
        tick();
        aresetn = 1'b1;
        for (int i = 0; i < NR; i++) echo_done[i] = echo_set[i];
        m_req_ready = 1'b1;
        repeat (3) tick();
        chk("t5_dropped_cmd", 64'(iss_paddr.size() - i0), 64'd0);
        chk("t5_fifo_empty", 64'(m_ord_valid), 64'd0);

        // Completion at full credit saturates and flags the error
        done_i = 4'b1000;
        tick();
        chk("t6_credit3_sat", 64'(dut.credit_q[3]), 64'd8);
        chk("t6_err_sticky", 64'(dut.err_q), 64'd1);

`ifdef TLB_SCHED_WRR_EN
        // Weighted round-robin: region 0 weight 3
        reset_dut();
        g0 = gnt_q.size();
        s_weight = 16'h0003;
        echo_en = 1'b1; m_req_ready = 1'b1; m_ord_ready = 1'b1;
        s_req_valid = 4'hF;
        for (int t = 0; t < 100 && (gnt_q.size() - g0) < 11; t++) tick();
        s_req_valid = '0;
        begin
            int exp_wrr [11] = '{0, 0, 0, 0, 1, 2, 3, 0, 0, 0, 0};
            chk("t7_grant_count", 64'(gnt_q.size() - g0 >= 11), 64'd1);
            for (int k = 0; k < 11; k++)
                chk($sformatf("t7_wrr%0d", k), 64'(gnt_q[g0+k]), 64'(exp_wrr[k]));
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
